// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the multiply/divide controller:
//     - MULDIV_W : default operand width
//     - op_e     : EX-stage mult/div operation encoding
//     - state_e  : controller FSM states
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam int MULDIV_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Sequences one multiply or divide at a time between the EX stage and the
//   external multiplier/divider units, then writes the 2W result to HI/LO.
//
//   Ports
//     clk, rst             clock (rising edge), synchronous active-high reset
//     op_valid, op         EX-stage mult/div request and its encoding (op_e)
//     src_a, src_b         operands (src_a is the dividend)
//     flush                exception flush, cancels the in-flight op
//     hold                 downstream stall, defers the HI/LO write
//     mult_start/div_start one-cycle launch pulses to the units
//     signed_op            1 for MULT/DIV, valid with the launch pulse
//     opa, opb             latched operands driven to the units
//     mult_ready/div_ready unit done pulses
//     mult_res/div_res     unit results (div_res = {rem, quot})
//     stall                holds EX while the op is unresolved
//     hilo_we              one-cycle HI/LO write strobe
//     hi_wdata, lo_wdata   HI/LO write data
//
//   Configuration
//     MULDIV_DIVZERO_FAST_EN : when defined, DIV/DIVU with src_b == 0 never
//     launches the divider and completes with hi = src_a, lo = all ones.
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int W = MULDIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [W-1:0]   src_a,
  input  logic [W-1:0]   src_b,
  input  logic           flush,
  input  logic           hold,
  output logic           mult_start,
  output logic           div_start,
  output logic           signed_op,
  output logic [W-1:0]   opa,
  output logic [W-1:0]   opb,
  input  logic           mult_ready,
  input  logic           div_ready,
  input  logic [2*W-1:0] mult_res,
  input  logic [2*W-1:0] div_res,
  output logic           stall,
  output logic           hilo_we,
  output logic [W-1:0]   hi_wdata,
  output logic [W-1:0]   lo_wdata
);

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } hilo_t;

  function automatic hilo_t split_result(input logic [2*W-1:0] res);
    hilo_t s;
    s.hi = res[2*W-1:W];
    s.lo = res[W-1:0];
    return s;
  endfunction

  state_e       state_q, state_d;
  logic         div_sel_q, div_sel_d;     // launched unit: 1 = divider
  logic         div0_q, div0_d;           // fast divide-by-zero in flight
  logic         signed_op_q, signed_op_d;
  logic         mult_start_q, mult_start_d;
  logic         div_start_q, div_start_d;
  logic [W-1:0] opa_q, opa_d;
  logic [W-1:0] opb_q, opb_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;

  logic         unit_ready;
  hilo_t        unit_split;
  logic         launch_div;

  // Only the unit that was launched may complete the op; the other unit's
  // ready pulse is ignored.
  assign unit_ready = div_sel_q ? div_ready : mult_ready;
  assign unit_split = split_result(div_sel_q ? div_res : mult_res);
  assign launch_div = (op == OP_DIV) || (op == OP_DIVU);

  always_comb begin
    // NOTE: every output of this block gets a default before the case so that
    // no path leaves a signal unassigned, which would infer a latch.
    state_d      = state_q;
    div_sel_d    = div_sel_q;
    div0_d       = div0_q;
    signed_op_d  = signed_op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    stall        = 1'b0;
    hilo_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flush) begin
          stall       = 1'b1;
          state_d     = ST_BUSY;
          div_sel_d   = launch_div;
          signed_op_d = (op == OP_MULT) || (op == OP_DIV);
          opa_d       = src_a;
          opb_d       = src_b;
`ifdef MULDIV_DIVZERO_FAST_EN
          div0_d       = launch_div && (src_b == '0);
          mult_start_d = !launch_div;
          div_start_d  = launch_div && (src_b != '0);
`else
          div0_d       = 1'b0;
          mult_start_d = !launch_div;
          div_start_d  = launch_div;
`endif
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        if (flush) begin
          // A fast divide-by-zero never launched a unit, and a ready arriving
          // with the flush has already drained it: nothing is left to wait on.
          state_d = (div0_q || unit_ready) ? ST_IDLE : ST_DRAIN;
        end else if (div0_q) begin
          state_d = ST_DONE;
          hi_d    = opa_q;
          lo_d    = '1;
        end else if (unit_ready) begin
          state_d = ST_DONE;
          hi_d    = unit_split.hi;
          lo_d    = unit_split.lo;
        end
      end

      ST_DONE: begin
        stall = hold;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          hilo_we = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // The flushed instruction is gone, so EX is free; only a new mult/div
        // must wait because the unit is still busy with the cancelled op.
        stall = op_valid && !flush;
        if (unit_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      div_sel_q    <= 1'b0;
      div0_q       <= 1'b0;
      signed_op_q  <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      div_sel_q    <= div_sel_d;
      div0_q       <= div0_d;
      signed_op_q  <= signed_op_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign signed_op  = signed_op_q;
  assign opa        = opa_q;
  assign opb        = opb_q;
  assign hi_wdata   = hi_q;
  assign lo_wdata   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Self-checking bench for muldiv_ctrl. A behavioural multiplier/divider
//   answers launch pulses after a chosen latency; expected HI/LO values come
//   from plain 64-bit arithmetic and expected timing from the op latency rule.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic [1:0]     op;
  logic [W-1:0]   src_a, src_b;
  logic           flush, hold;
  logic           mult_start, div_start, signed_op;
  logic [W-1:0]   opa, opb;
  logic           mult_ready, div_ready;
  logic [2*W-1:0] mult_res, div_res;
  logic           stall, hilo_we;
  logic [W-1:0]   hi_wdata, lo_wdata;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Behavioural unit state
  int          unit_lat  = 1;
  int          mult_due  = -1;
  int          div_due   = -1;
  logic [63:0] mult_val  = '0;
  logic [63:0] div_val   = '0;
  logic [31:0] last_hi, last_lo;

  muldiv_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .hold(hold),
    .mult_start(mult_start), .div_start(div_start), .signed_op(signed_op),
    .opa(opa), .opb(opb), .mult_ready(mult_ready), .div_ready(div_ready),
    .mult_res(mult_res), .div_res(div_res), .stall(stall),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // {hi, lo} as the architecture defines it: product, or {rem, quot}.
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: if (b == 0) r = {a, 32'hFFFF_FFFF};
             else begin r[31:0] = 32'(sa / sb); r[63:32] = 32'(sa % sb); end
      default: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else begin r[31:0] = 32'(ua / ub); r[63:32] = 32'(ua % ub); end
    endcase
    return r;
  endfunction

  // Advance to the next cycle and drive any unit ready that falls due.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mult_ready = (cyc == mult_due);
    mult_res   = mult_ready ? mult_val : '0;
    if (mult_ready) mult_due = -1;
    div_ready  = (cyc == div_due);
    div_res    = div_ready ? div_val : '0;
    if (div_ready) div_due = -1;
  endtask

  // Let combinational outputs settle; the units react to launch pulses.
  task automatic settle();
    #1;
    if (mult_start) begin
      mult_due = cyc + unit_lat;
      mult_val = ref_hilo(signed_op ? 2'b00 : 2'b01, opa, opb);
    end
    if (div_start) begin
      div_due = cyc + unit_lat;
      div_val = ref_hilo(signed_op ? 2'b10 : 2'b11, opa, opb);
    end
  endtask

  // One complete op with no flush; hold_n cycles of hold in DONE; junk drives
  // spurious ready pulses from the unit that was not launched.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold_n, input bit junk);
    logic [63:0] e;
    bit          is_div, fast;
    int          t_done, t_we;
    e      = ref_hilo(o, a, b);
    is_div = o[1];
    fast   = 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
    fast   = is_div && (b == 0);
`endif
    t_done   = fast ? 2 : lat + 2;
    t_we     = t_done + hold_n;
    unit_lat = lat;
    for (int c = 0; c <= t_we + 1; c++) begin
      tick();
      op_valid = (c <= t_we);
      op       = o;
      src_a    = a;
      src_b    = b;
      flush    = 1'b0;
      hold     = (c >= t_done) && (c < t_we);
      if (junk && !fast && c >= 1 && c <= lat) begin
        if (is_div) begin mult_ready = 1'b1; mult_res = {$urandom, $urandom}; end
        else        begin div_ready  = 1'b1; div_res  = {$urandom, $urandom}; end
      end
      settle();
      check("stall", stall, c < t_we);
      check("hilo_we", hilo_we, c == t_we);
      check("mult_start", mult_start, (c == 1) && !is_div);
      check("div_start", div_start, (c == 1) && is_div && !fast);
      if (c == 1) begin
        check("signed_op", signed_op, !o[0]);
        check("opa", opa, a);
        check("opb", opb, b);
      end
      if (c >= t_done && c <= t_we) begin
        check("hi_wdata", hi_wdata, e[63:32]);
        check("lo_wdata", lo_wdata, e[31:0]);
      end
      if (c == t_we) begin
        last_hi = hi_wdata;
        last_lo = lo_wdata;
      end
    end
    mult_ready = 1'b0;
    div_ready  = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic [63:0] e;

    rst = 1'b1; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    flush = 1'b0; hold = 1'b0; mult_ready = 1'b0; div_ready = 1'b0;
    mult_res = '0; div_res = '0;

    // Reset state
    tick(); tick(); settle();
    check("rst_stall", stall, 1'b0);
    check("rst_hilo_we", hilo_we, 1'b0);
    check("rst_starts", {mult_start, div_start}, 2'b00);
    check("rst_hilo", {hi_wdata, lo_wdata}, 64'h0);
    check("rst_ops", {opa, opb}, 64'h0);
    tick(); rst = 1'b0; settle();

    // Signed multiply, unit latency 4 -> hilo_we 6 cycles after op_valid
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 4, 0, 1'b0);
    check("mult_hi_const", last_hi, 32'hFFFF_FFFF);
    check("mult_lo_const", last_lo, 32'hFFFF_FFFA);

    // Unsigned divide with spurious multiplier ready pulses
    run_op(OP_DIVU, 32'd100, 32'd7, 6, 0, 1'b1);
    check("divu_hi_const", last_hi, 32'd2);
    check("divu_lo_const", last_lo, 32'd14);

    // Reset while BUSY, then a stray divider ready
    unit_lat = 4;
    for (int c = 0; c <= 8; c++) begin
      tick();
      op_valid = (c <= 2);
      op       = OP_DIV;
      src_a    = 32'h1234_5678;
      src_b    = 32'd5;
      rst      = (c == 2);
      if (c == 7) begin div_ready = 1'b1; div_res = 64'hDEAD_BEEF_CAFE_F00D; end
      settle();
      if (c == 1) check("rstb_div_start", div_start, 1'b1);
      if (c >= 3) begin
        check("rstb_hilo_we", hilo_we, 1'b0);
        check("rstb_stall", stall, 1'b0);
      end
      if (c == 3) begin
        check("rstb_starts", {mult_start, div_start}, 2'b00);
        check("rstb_hilo", {hi_wdata, lo_wdata}, 64'h0);
        check("rstb_ops", {opa, opb}, 64'h0);
      end
    end
    rst = 1'b0;
    div_ready = 1'b0;

    // Hold in DONE for 3 cycles
    run_op(OP_MULTU, 32'hDEAD_BEEF, 32'h0001_0003, 3, 3, 1'b0);

    // Signed divide by zero
    run_op(OP_DIV, 32'h8765_4321, 32'd0, 5, 0, 1'b0);
    check("div0_hi", last_hi, 32'h8765_4321);
    check("div0_lo", last_lo, 32'hFFFF_FFFF);

    // Flush in BUSY -> DRAIN; next op waits for mult_ready
    for (int c = 0; c <= 13; c++) begin
      tick();
      op_valid = (c <= 2) || (c >= 4 && c <= 12);
      flush    = (c == 2);
      hold     = 1'b0;
      if (c <= 2) begin op = OP_MULT; src_a = 32'h7FFF_0001; src_b = 32'h0000_1234; end
      else        begin op = OP_DIVU; src_a = 32'd100;       src_b = 32'd7;         end
      unit_lat = (c <= 2) ? 5 : 3;
      settle();
      check("drain_stall", stall, (c <= 2) || (c >= 4 && c <= 11));
      check("drain_hilo_we", hilo_we, c == 12);
      check("drain_mult_start", mult_start, c == 1);
      check("drain_div_start", div_start, c == 8);
      if (c == 12) check("drain_hilo", {hi_wdata, lo_wdata}, {32'd2, 32'd14});
    end

    // Ready coincident with flush in BUSY -> straight to IDLE
    e = ref_hilo(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 0; c <= 10; c++) begin
      tick();
      op_valid = (c <= 4) || (c >= 5 && c <= 9);
      flush    = (c == 4);
      if (c <= 4) begin op = OP_DIV;   src_a = 32'hFFFF_FF00; src_b = 32'd9;         end
      else        begin op = OP_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; end
      unit_lat = (c <= 4) ? 3 : 2;
      settle();
      check("rdyfl_stall", stall, c <= 8);
      check("rdyfl_hilo_we", hilo_we, c == 9);
      check("rdyfl_div_start", div_start, c == 1);
      check("rdyfl_mult_start", mult_start, c == 6);
      if (c == 9) check("rdyfl_hilo", {hi_wdata, lo_wdata}, e);
    end

    // Flush in DONE suppresses the write
    unit_lat = 2;
    for (int c = 0; c <= 6; c++) begin
      tick();
      op_valid = (c <= 4);
      flush    = (c == 4);
      op       = OP_MULTU;
      src_a    = 32'd11;
      src_b    = 32'd13;
      settle();
      check("flDone_hilo_we", hilo_we, 1'b0);
      check("flDone_stall", stall, c <= 3);
    end
    flush = 1'b0;

    // Randomised ops
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, $urandom_range(1, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
